// File: rtl/image_row_readout_ctrl.sv
// Row readout sequencer: takes pixels over valid/ready, shifts them MSB-first into the
// image-row shift register, strobes a parallel load per row and flags frame completion.
module image_row_readout_ctrl #(
    parameter int IMAGE_SIZE = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [7:0]                    pix_data,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic                          sr_shift_in,
    output logic                          sr_shift_en,
    output logic                          sr_load,
    output logic                          busy,
    output logic                          row_done,
    output logic                          frame_done,
    output logic [$clog2(IMAGE_SIZE)-1:0] row_idx
);

    localparam int PIXEL_BITS = 8;
    localparam int ROW_W      = $clog2(IMAGE_SIZE);
    // One extra bit so the counter can hold IMAGE_SIZE itself ("all pixels accepted").
    localparam int PX_W       = $clog2(IMAGE_SIZE + 1);

    localparam logic [2:0]       LAST_BIT = 3'(PIXEL_BITS - 1);
    localparam logic [PX_W-1:0]  PX_FULL  = PX_W'(IMAGE_SIZE);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t                state;
    logic [PIXEL_BITS-1:0] pix_q;
    logic                  pix_full;
    logic [2:0]            bit_cnt;
    logic [PX_W-1:0]       px_cnt;
    logic                  last_bit;
    logic                  accept;

    assign last_bit = (bit_cnt == LAST_BIT);

    // A new byte can enter when the holding register is empty or is shifting its final bit.
    assign pix_ready = (state == SHIFT) && (px_cnt != PX_FULL) && (!pix_full || last_bit);
    assign accept    = pix_valid && pix_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pix_q    <= '0;
            pix_full <= 1'b0;
            bit_cnt  <= '0;
            px_cnt   <= '0;
            row_idx  <= '0;
        end else if (abort) begin
            state    <= IDLE;
            pix_full <= 1'b0;
            bit_cnt  <= '0;
            px_cnt   <= '0;
            row_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SHIFT;
                        pix_full <= 1'b0;
                        bit_cnt  <= '0;
                        px_cnt   <= '0;
                        row_idx  <= '0;
                    end
                end

                SHIFT: begin
                    if (accept) begin
                        pix_q  <= pix_data;
                        px_cnt <= px_cnt + PX_W'(1);
                    end
                    // The bit counter only advances while a byte is present, so a stall holds it at 0.
                    if (pix_full) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            pix_full <= accept;
                            if (px_cnt == PX_FULL) begin
                                state <= LOAD;
                            end
                        end
                    end else if (accept) begin
                        pix_full <= 1'b1;
                    end
                end

                LOAD: begin
                    px_cnt <= '0;
                    if (row_idx == ROW_LAST) begin
                        state <= IDLE;
                    end else begin
                        row_idx <= row_idx + ROW_W'(1);
                        state   <= SHIFT;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign sr_shift_en = (state == SHIFT) && pix_full;
    assign sr_shift_in = sr_shift_en & pix_q[LAST_BIT - bit_cnt];
    assign sr_load     = (state == LOAD);
    assign row_done    = (state == LOAD);
    assign frame_done  = (state == LOAD) && (row_idx == ROW_LAST);

endmodule
